// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: hex glyph table, digit count and the all-anodes-off pattern.
// Combinational helpers only; no latency or backpressure.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

  // Indexed by nibble value; bit 0 is segment a, bit 6 is segment g.
  localparam logic [15:0][6:0] HEX7 = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7(input logic [3:0] value);
    return HEX7[value];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-high 7-segment pattern (a..g on bits 0..6).
// Purely combinational; no backpressure.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: per-frame snapshot, blank-then-show slots, registered pins.
// Outputs lag the scan counter by one cycle; ena low freezes the scan and blanks the display.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]     snap_dp;
  logic [NUM_DIGITS-1:0]     snap_en;

  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;
  logic       show;

  // Decode always works from the snapshot so a mid-frame input change cannot tear the display.
  assign cur_nibble = snap_digits[{idx, 2'b00} +: 4];
  assign show       = (cnt >= BLANK_END) && snap_en[idx];

  hex_to_seg7 u_hex (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      an          <= AN_ALL_OFF;
      seg         <= '0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (cnt == '0 && idx == '0) begin
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_en     <= digit_en;
        frame_start <= 1'b1;
      end else begin
        frame_start <= 1'b0;
      end

      if (show) begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= cur_seg;
        dp  <= snap_dp[idx];
      end else begin
        an  <= AN_ALL_OFF;
        seg <= '0;
        dp  <= 1'b0;
      end
    end else begin
      an          <= AN_ALL_OFF;
      seg         <= '0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with an 8-cycle slot, 2-cycle blank and 32-cycle frame.
module tb_seg7_scan_ctrl;

  logic        clk    = 1'b0;
  logic        clk_on = 1'b0;
  logic        rst_n  = 1'b1;
  logic        ena    = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in  = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_chk  = 0;
  int n_pass = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .digits      (digits),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  initial begin
    wait (clk_on);
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " seg"}, 32'(seg), 32'h0);
    chk({tag, " dp"}, 32'(dp), 32'h0);
    chk({tag, " fs"}, 32'(frame_start), 32'h0);
  endtask

  // Entered at the negedge right after a snapshot-load edge; leaves at the next one.
  // segs = {slot3, slot2, slot1, slot0} hand-computed glyphs.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] en,
                             input logic [3:0] dpv, input int chg_at, input logic [15:0] chg_val,
                             input int frz_at);
    for (int k = 0; k < 32; k++) begin
      int c;
      int s;
      logic on;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      c = k % 8;
      s = k / 8;
      on = (c >= 2) && en[s];
      e_an = on ? ~(4'b0001 << s) : 4'hF;
      e_seg = on ? segs[7*s +: 7] : 7'h0;
      chk($sformatf("%s k%0d an", tag, k), 32'(an), 32'(e_an));
      chk($sformatf("%s k%0d seg", tag, k), 32'(seg), 32'(e_seg));
      chk($sformatf("%s k%0d dp", tag, k), 32'(dp), 32'(on & dpv[s]));
      chk($sformatf("%s k%0d fs", tag, k), 32'(frame_start), 32'(k == 0));
      if (k == chg_at) digits = chg_val;
      if (k == frz_at) begin
        ena = 1'b0;
        for (int f = 0; f < 5; f++) begin
          tick(1);
          chk_blank($sformatf("%s frz%0d", tag, f));
        end
        ena = 1'b1;
      end
      tick(1);
    end
  endtask

  initial begin
    // Reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1 chk_blank("rst");
    ena      = 1'b1;
    digits   = 16'h1234;
    dp_in    = 4'b0001;
    digit_en = 4'b1111;
    #5 rst_n = 1'b1;
    clk_on = 1'b1;
    tick(1);

    check_frame("scan1", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0001, -1, 16'h0, -1);
    check_frame("scan2", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0001, -1, 16'h0, -1);
    check_frame("tear",  {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 4'b0001, 12, 16'hABCD, -1);
    digit_en = 4'b0011;
    check_frame("abcd",  {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 4'b0001, -1, 16'h0, -1);
    digit_en = 4'b1111;
    check_frame("den",   {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0011, 4'b0001, -1, 16'h0, -1);
    check_frame("frz",   {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 4'b0001, -1, 16'h0, 11);
    check_frame("post",  {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1111, 4'b0001, -1, 16'h0, -1);

    // Mid-frame reset during slot 2 with a new value waiting.
    digits = 16'h5678;
    tick(20);
    chk("mid an", 32'(an), 32'hB);
    chk("mid seg", 32'(seg), 32'h7C);
    #1 rst_n = 1'b0;
    #1 chk_blank("mrst");
    #1 rst_n = 1'b1;
    tick(1);
    check_frame("new",   {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111, 4'b0001, -1, 16'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
